// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter/sequencer sharing one WIDTH-bit JK flip-flop bank between two requesters.
// Optional abort support is compiled in when the macro JKB_ABORT_EN is defined.
module jk_bank_arbiter #(
  parameter int WIDTH = 8,
  parameter int RPT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [1:0]       op0,
  input  logic [WIDTH-1:0] mask0,
  input  logic [RPT_W-1:0] rpt0,
  input  logic             req1,
  input  logic [1:0]       op1,
  input  logic [WIDTH-1:0] mask1,
  input  logic [RPT_W-1:0] rpt1,
  input  logic             abort,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             owner,
  output logic             aborted,
  output logic [1:0]       dbg_state
);

  // Handshake: a requester raises req with op/mask/rpt stable and holds them until its
  // one-cycle ack; req is only sampled in IDLE, so a req still high there is a new request.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [1:0]       op_q, op_d;
  logic [RPT_W-1:0] cnt_q, cnt_d;
  logic             owner_q, owner_d;
  logic             last_grant_q, last_grant_d;
  logic             busy_q, busy_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             aborted_q, aborted_d;
  logic             grant_sel;
  logic             abort_hit;

`ifdef JKB_ABORT_EN
  assign abort_hit = abort;
`else
  logic unused_abort;
  assign unused_abort = abort;
  assign abort_hit    = 1'b0;
`endif

  // Per-bit JK update restricted to the masked cells; no interaction between bits.
  function automatic logic [WIDTH-1:0] jk_apply(input logic [WIDTH-1:0] cur,
                                                input logic [1:0]       op,
                                                input logic [WIDTH-1:0] m);
    logic [WIDTH-1:0] nxt;
    case (op)
      2'b01:   nxt = '0;
      2'b10:   nxt = '1;
      2'b11:   nxt = ~cur;
      default: nxt = cur;
    endcase
    return (cur & ~m) | (nxt & m);
  endfunction

  always_comb begin
    state_d      = state_q;
    q_d          = q_q;
    op_d         = op_q;
    mask_d       = mask_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    busy_d       = busy_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    aborted_d    = 1'b0;
    grant_sel    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          grant_sel = (req0 && req1) ? ~last_grant_q : req1;
          owner_d   = grant_sel;
          op_d      = grant_sel ? op1 : op0;
          mask_d    = grant_sel ? mask1 : mask0;
          cnt_d     = grant_sel ? rpt1 : rpt0;
          busy_d    = 1'b1;
          state_d   = S_APPLY;
        end
      end
      S_APPLY: begin
        if (abort_hit) begin
          // The aborting cycle's application is dropped entirely.
          ack0_d    = ~owner_q;
          ack1_d    = owner_q;
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          q_d = jk_apply(q_q, op_q, mask_q);
          if (cnt_q == '0) begin
            ack0_d  = ~owner_q;
            ack1_d  = owner_q;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q - RPT_W'(1);
          end
        end
      end
      S_DONE: begin
        last_grant_d = owner_q;
        busy_d       = 1'b0;
        state_d      = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      q_q          <= '0;
      op_q         <= 2'b00;
      mask_q       <= '0;
      cnt_q        <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      busy_q       <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      q_q          <= q_d;
      op_q         <= op_d;
      mask_q       <= mask_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      busy_q       <= busy_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      aborted_q    <= aborted_d;
    end
  end

  assign q         = q_q;
  assign busy      = busy_q;
  assign owner     = owner_q;
  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign aborted   = aborted_q;
  assign dbg_state = state_q;

endmodule
